// File: rtl/seq_divider_param.sv
// Multi-cycle restoring divider, WIDTH bits, optional signed mode, Run/Busy/Ready handshake.
// Results land WIDTH+1 cycles after Run is accepted; a zero divisor lands after one cycle.
module seq_divider_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic             q_neg;
    logic             r_neg;
    logic             zero_pend;
    logic             ovf_pend;
    logic [WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic             sgn_in;
    logic             accept;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] trial;

    always_comb begin
        sgn_in     = SIGNED_EN && Signed;
        accept     = Run && (state == IDLE || state == DONE);
        dvd_mag_in = (sgn_in && Dividend[WIDTH-1]) ? -Dividend : Dividend;
        dvs_mag_in = (sgn_in && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
        // quo doubles as the dividend shift register: its MSB feeds the remainder
        shifted    = {rem, quo[WIDTH-1]};
        borrow     = shifted < {1'b0, dvs_mag};
        trial      = shifted[WIDTH-1:0] - dvs_mag;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_pend <= 1'b0;
            ovf_pend  <= 1'b0;
            dvd_raw   <= '0;
            dvs_mag   <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            Busy      <= 1'b0;
            Ready     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else if (accept) begin
            q_neg     <= sgn_in && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            r_neg     <= sgn_in && Dividend[WIDTH-1];
            ovf_pend  <= sgn_in && (Dividend == MIN_NEG) && (Divisor == '1);
            dvd_raw   <= Dividend;
            dvs_mag   <= dvs_mag_in;
            quo       <= dvd_mag_in;
            rem       <= '0;
            cnt       <= CW'(WIDTH - 1);
            Ready     <= 1'b0;
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
            if (Divisor == '0) begin
                state     <= DONE;
                zero_pend <= 1'b1;
                Busy      <= 1'b0;
            end else begin
                state     <= CALC;
                zero_pend <= 1'b0;
                Busy      <= 1'b1;
            end
        end else begin
            case (state)
                CALC: begin
                    rem <= borrow ? shifted[WIDTH-1:0] : trial;
                    quo <= {quo[WIDTH-2:0], ~borrow};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    Quotient  <= q_neg ? -quo : quo;
                    Remainder <= r_neg ? -rem : rem;
                    Overflow  <= ovf_pend;
                    Busy      <= 1'b0;
                    Ready     <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // zero divisor: publish the fixed result one cycle after accept
                    if (zero_pend) begin
                        Quotient  <= '1;
                        Remainder <= dvd_raw;
                        DivByZero <= 1'b1;
                        Ready     <= 1'b1;
                        zero_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_param.sv
// Bench for seq_divider_param: a 32-bit signed-capable instance and an 8-bit unsigned-only instance.
module tb_seq_divider_param;

    logic        clk;
    logic        rst_n;

    logic        run_a, sgn_a, busy_a, rdy_a, dbz_a, ovf_a;
    logic [31:0] dvd_a, dvs_a, q_a, r_a;

    logic        run_b, sgn_b, busy_b, rdy_b, dbz_b, ovf_b;
    logic [7:0]  dvd_b, dvs_b, q_b, r_b;

    int nchk = 0;
    int nerr = 0;

    seq_divider_param #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_a (
        .clk(clk), .Reset(rst_n), .Run(run_a), .Signed(sgn_a),
        .Dividend(dvd_a), .Divisor(dvs_a), .Busy(busy_a), .Ready(rdy_a),
        .Quotient(q_a), .Remainder(r_a), .DivByZero(dbz_a), .Overflow(ovf_a)
    );

    seq_divider_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_b (
        .clk(clk), .Reset(rst_n), .Run(run_b), .Signed(sgn_b),
        .Dividend(dvd_b), .Divisor(dvs_b), .Busy(busy_b), .Ready(rdy_b),
        .Quotient(q_b), .Remainder(r_b), .DivByZero(dbz_b), .Overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder follows dividend sign
    function automatic void model32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        longint sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            if (sa == -64'sd2147483648 && sb == -64'sd1) begin
                q  = 32'h8000_0000;
                r  = 32'd0;
                ov = 1'b1;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input string tag);
        int n;
        int busy_bad;
        @(negedge clk);
        run_a = 1'b1; sgn_a = s; dvd_a = a; dvs_a = b;
        @(negedge clk);
        run_a = 1'b0; sgn_a = 1'($urandom); dvd_a = $urandom; dvs_a = $urandom;
        chk({tag, ".rdy_drop"}, 64'(rdy_a), 64'(0));
        chk({tag, ".busy0"}, 64'(busy_a), 64'(b != 32'd0));
        n = 0;
        busy_bad = 0;
        while (!rdy_a && n < 100) begin
            if (b != 32'd0 && !busy_a) busy_bad++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'((b == 32'd0) ? 1 : 33));
        chk({tag, ".busy_hold"}, 64'(busy_bad), 64'(0));
        chk({tag, ".busy_end"}, 64'(busy_a), 64'(0));
        chk({tag, ".q"}, 64'(q_a), 64'(eq));
        chk({tag, ".r"}, 64'(r_a), 64'(er));
        chk({tag, ".dbz"}, 64'(dbz_a), 64'(edz));
        chk({tag, ".ovf"}, 64'(ovf_a), 64'(eov));
    endtask

    task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        logic [7:0] eq, er;
        eq = (b == 8'd0) ? 8'hFF : a / b;
        er = (b == 8'd0) ? a : a % b;
        @(negedge clk);
        run_b = 1'b1; sgn_b = s; dvd_b = a; dvs_b = b;
        @(negedge clk);
        run_b = 1'b0; dvd_b = 8'($urandom); dvs_b = 8'($urandom);
        chk({tag, ".rdy_drop"}, 64'(rdy_b), 64'(0));
        n = 0;
        while (!rdy_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'((b == 8'd0) ? 1 : 9));
        chk({tag, ".q"}, 64'(q_b), 64'(eq));
        chk({tag, ".r"}, 64'(r_b), 64'(er));
        chk({tag, ".dbz"}, 64'(dbz_b), 64'(b == 8'd0));
        chk({tag, ".ovf"}, 64'(ovf_b), 64'(0));
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        s, edz, eov;
        int          n;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1'b0};
        tbl[5] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1, 1'b0};
        tbl[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
        tbl[8] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};

        rst_n = 1'b0;
        run_a = 1'b0; sgn_a = 1'b0; dvd_a = '0; dvs_a = '0;
        run_b = 1'b0; sgn_b = 1'b0; dvd_b = '0; dvs_b = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy_a), 64'(0));
        chk("rst.rdy", 64'(rdy_a), 64'(0));
        chk("rst.q", 64'(q_a), 64'(0));
        chk("rst.r", 64'(r_a), 64'(0));
        chk("rst.flags", 64'({dbz_a, ovf_a}), 64'(0));
        chk("rst.rdy8", 64'(rdy_b), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++)
            op32(tbl[i].sgn, tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r,
                 tbl[i].dbz, tbl[i].ovf, $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            model32(s, a, b, eq, er, edz, eov);
            op32(s, a, b, eq, er, edz, eov, $sformatf("rnd%0d", i));
        end

        // Run while busy must be ignored
        @(negedge clk);
        run_a = 1'b1; sgn_a = 1'b0; dvd_a = 32'd100; dvs_a = 32'd7;
        @(negedge clk);
        run_a = 1'b0;
        n = 0;
        while (!rdy_a && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                run_a = 1'b1; dvd_a = 32'd50; dvs_a = 32'd5;
            end else begin
                run_a = 1'b0;
            end
        end
        chk("ign.lat", 64'(n), 64'(33));
        chk("ign.q", 64'(q_a), 64'(14));
        chk("ign.r", 64'(r_a), 64'(2));

        // Reset mid-operation
        @(negedge clk);
        run_a = 1'b1; dvd_a = 32'd100; dvs_a = 32'd7;
        @(negedge clk);
        run_a = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", 64'(busy_a), 64'(0));
        chk("mid_rst.rdy", 64'(rdy_a), 64'(0));
        chk("mid_rst.q", 64'(q_a), 64'(0));
        chk("mid_rst.r", 64'(r_a), 64'(0));
        chk("mid_rst.flags", 64'({dbz_a, ovf_a}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle.busy", 64'(busy_a), 64'(0));
        chk("idle.rdy", 64'(rdy_a), 64'(0));
        op32(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0, "post_rst");

        // 8-bit unsigned-only instance, Signed input ignored, back-to-back in DONE
        op8(1'b1, 8'd200, 8'd3, "w8_a");
        op8(1'b0, 8'd100, 8'd7, "w8_b2b");
        op8(1'b1, 8'd5, 8'd0, "w8_dbz");
        op8(1'b1, 8'd128, 8'd255, "w8_min");
        for (int i = 0; i < 20; i++)
            op8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), $sformatf("w8_rnd%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
